instr_loader: RTL and testbench
===============================

# instr_loader

Host-side instruction loader for the TPU. Accepts the program as a byte stream from the 8-bit user input pins, assembles 16-bit instructions, and writes them into an 8-entry instruction memory. The top-level fetch FSM reads that memory through an asynchronous read port. The loader raises a one-cycle start pulse once the program is complete, so the fetch FSM starts from loaded contents, not hard-coded ones.

## Interface
- DEPTH, 8, number of 16-bit instruction entries; power of two, ≥2
- AW, $clog2(DEPTH), write/read pointer width
- clk  in  1  clock
- reset  in  1  reset; synchronous, active-high; clock clk
- clear  in  1  synchronous restart of loading; does not touch memory contents
- host_data  in  8  program byte from the host (ui_in)
- host_valid  in  1  host_data valid this cycle
- host_ready  out  1  loader can accept a byte this cycle
- rd_addr  in  AW  fetch-side read address
- rd_data  out  16  mem[rd_addr], combinational
- instr_count  out  AW+1  number of instructions written since reset/clear
- prog_done  out  1  level; program complete, loader idle
- start  out  1  one-cycle pulse on entry to DONE
- err  out  1  checksum mismatch (0 when LOADER_CHECKSUM_EN is undefined)

## Operation
- Handshake: a byte is accepted on a rising edge where host_valid && host_ready. host_ready is combinational from state: 1 in HI, LO and CHK; 0 in DONE and ERR.
- States:
  - HI: accepted byte is latched into hi_byte; go to LO.
  - LO: accepted byte forms {hi_byte, host_data}, which is written to mem[wr_ptr]; wr_ptr and instr_count increment. If the word == 16'h0000 (END) or wr_ptr == DEPTH-1, go to CHK (macro defined) or DONE (macro undefined); otherwise go to HI.
  - CHK: accepted byte is compared against the running checksum. Match → DONE. Mismatch → ERR.
  - DONE: prog_done=1; host bytes are ignored.
  - ERR: err=1, prog_done=0; host bytes are ignored.
- Byte order: high byte first. Opcode occupies bits [15:13].
- END word is stored in memory, so the fetch FSM sees the terminator.
- Full: if DEPTH words arrive without an END word, loading terminates with all entries written. instr_count reads DEPTH.
- clear: from any state, go to HI with wr_ptr=0, instr_count=0, checksum=0, err=0. Memory is retained. clear has priority over a byte accepted in the same cycle; that byte is dropped.
- Reset mid-load: same as clear, and additionally all memory entries = 16'h0000.
- Read during write to the same address returns the old data. The new data is visible the next cycle.

## Timing
- Reset values:
  - Outputs: host_ready=1, prog_done=0, start=0, err=0, instr_count=0.
  - rd_data=16'h0000 for any rd_addr.
  - Internal: state=HI, wr_ptr=0.
- Memory write occurs on the edge that accepts the low byte.
- Transition to DONE happens on that same edge (or on the CHK-byte edge). prog_done and start are high in the following cycle. start drops after exactly one cycle.
- Minimum program time: 2 cycles per instruction plus 1 checksum cycle if enabled.
- Back-to-back bytes with host_valid held high are accepted every cycle.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - An 8-bit XOR checksum is accumulated over every accepted instruction byte.
  - One trailing checksum byte is required after the final word.
  - Mismatch → ERR, err=1, no start pulse.
- Undefined:
  - No CHK/ERR states and no checksum register.
  - err tied 0.
  - DONE is entered directly after the final word.

## Test plan
- Reset then read: with no stimulus, all 8 rd_addr values → rd_data=0000; host_ready=1, prog_done=0.
- Load 3 words: bytes 20,0F, 40,00, 00,00 → mem[0..2]=200F,4000,0000; instr_count=3. start pulses once, 1 cycle after the last byte; host_ready=0 afterwards.
- Full without END: 16 bytes forming 2001..2008 → mem[7]=2008, instr_count=8, prog_done=1. A 17th byte is ignored.
- clear mid-word: send 20, then assert clear together with 0F → byte dropped, state=HI. Then send 40,00,00,00 → mem[0]=4000.
- Checksum (LOADER_CHECKSUM_EN): bytes 20,0F,00,00 then 2F → start pulse, err=0. Repeat with trailing byte 2E → err=1, prog_done=0, no start.

Source files
------------

// File: rtl/instr_loader.sv
// instr_loader: assembles a host byte stream (high byte first) into 16-bit
// instructions and writes them into a small instruction memory. The fetch
// side reads that memory through an asynchronous port. A one-cycle start
// pulse is raised when loading completes.
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   defined   -> a trailing XOR checksum byte is required after the last word;
//                a mismatch parks the loader in ERR (err=1, no start pulse).
//   undefined -> no checksum state; err is tied low.
//
// Handshake: a host byte is transferred on a rising clk edge where
// host_valid && host_ready. host_ready depends only on the current state,
// never on host_valid, so the host may hold host_valid high and stream one
// byte per cycle.
module instr_loader #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic [7:0]    host_data,
  input  logic          host_valid,
  output logic          host_ready,
  input  logic [AW-1:0] rd_addr,
  output logic [15:0]   rd_data,
  output logic [AW:0]   instr_count,
  output logic          prog_done,
  output logic          start,
  output logic          err
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_HI, S_LO, S_CHK, S_DONE, S_ERR} state_t;
`else
  typedef enum logic [1:0] {S_HI, S_LO, S_DONE} state_t;
`endif

  state_t        state, state_next;
  logic [7:0]    hi_byte;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          start_r;
  logic [15:0]   mem [0:DEPTH-1];
  logic          accept;
  logic [15:0]   word;
  logic          last_word;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]    chk;
`endif

  assign accept    = host_valid && host_ready;
  assign word      = {hi_byte, host_data};
  // Loading stops on the END word (stored like any other) or when the last
  // entry has just been filled.
  assign last_word = (word == 16'h0000) || (wr_ptr == AW'(DEPTH - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_HI;
    else       state <= state_next;
  end

  // Next-state and state-decoded outputs; clear overrides any accepted byte.
  always_comb begin
    state_next = state;
    host_ready = 1'b0;
    case (state)
      S_HI: begin
        host_ready = 1'b1;
        if (accept) state_next = S_LO;
      end
      S_LO: begin
        host_ready = 1'b1;
        if (accept) begin
`ifdef LOADER_CHECKSUM_EN
          state_next = last_word ? S_CHK : S_HI;
`else
          state_next = last_word ? S_DONE : S_HI;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        host_ready = 1'b1;
        if (accept) state_next = (host_data == chk) ? S_DONE : S_ERR;
      end
`endif
      default: state_next = state;
    endcase
    if (clear) state_next = S_HI;
  end

  // Datapath: byte latch, memory write, pointers, checksum and start pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_byte <= 8'h00;
      wr_ptr  <= '0;
      count   <= '0;
      start_r <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      chk     <= 8'h00;
`endif
      for (int i = 0; i < DEPTH; i++) mem[i] <= 16'h0000;
    end else if (clear) begin
      // Memory is deliberately retained across clear.
      wr_ptr  <= '0;
      count   <= '0;
      start_r <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      chk     <= 8'h00;
`endif
    end else begin
      start_r <= (state != S_DONE) && (state_next == S_DONE);
      if (accept && state == S_HI) begin
        hi_byte <= host_data;
`ifdef LOADER_CHECKSUM_EN
        chk     <= chk ^ host_data;
`endif
      end
      if (accept && state == S_LO) begin
        mem[wr_ptr] <= word;
        wr_ptr      <= wr_ptr + AW'(1);
        count       <= count + (AW + 1)'(1);
`ifdef LOADER_CHECKSUM_EN
        chk         <= chk ^ host_data;
`endif
      end
    end
  end

  // Asynchronous read: a same-cycle write is seen only after the edge.
  assign rd_data     = mem[rd_addr];
  assign instr_count = count;
  assign start       = start_r;
  assign prog_done   = (state == S_DONE);
`ifdef LOADER_CHECKSUM_EN
  assign err         = (state == S_ERR);
`else
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_instr_loader.sv
// Testbench for instr_loader: directed programs from the test plan plus
// randomized programs, checked against a word-level model of the memory.
module tb_instr_loader;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          clear;
  logic [7:0]    host_data;
  logic          host_valid;
  logic          host_ready;
  logic [AW-1:0] rd_addr;
  logic [15:0]   rd_data;
  logic [AW:0]   instr_count;
  logic          prog_done;
  logic          start;
  logic          err;

  instr_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .host_data(host_data), .host_valid(host_valid), .host_ready(host_ready),
    .rd_addr(rd_addr), .rd_data(rd_data), .instr_count(instr_count),
    .prog_done(prog_done), .start(start), .err(err)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  logic [35:0] exp_q[$];          // {cycle start must be seen, instr_count}
  logic [15:0] mem_m [DEPTH];     // reference image of instruction memory
  logic [15:0] prog_q[$];         // words of the program being driven
  int unsigned last_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every start pulse must match the oldest expected completion.
  task automatic monitor();
    logic [35:0] e;
    forever begin
      @(negedge clk);
      if (!reset && start) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL start_unexpected: got 1 expected 0 (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          check("start_cycle", cyc, e[35:4]);
          check("start_count", 32'(instr_count), 32'(e[3:0]));
          check("start_prog_done", 32'(prog_done), 32'd1);
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input logic exp_ready);
    @(negedge clk);
    host_data  = b;
    host_valid = 1'b1;
    #1 check("host_ready", 32'(host_ready), 32'(exp_ready));
    @(posedge clk);
    #1 last_cyc = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      host_valid = 1'b0;
    end
  endtask

  task automatic do_clear();
    @(negedge clk);
    host_valid = 1'b0;
    clear      = 1'b1;
    @(negedge clk);
    clear      = 1'b0;
  endtask

  task automatic check_mem();
    for (int a = 0; a < DEPTH; a++) begin
      @(negedge clk);
      rd_addr = AW'(a);
      #1 check("rd_data", 32'(rd_data), 32'(mem_m[a]));
    end
  endtask

  // Drive prog_q from a freshly cleared loader and check the outcome.
  // A program ends at the first zero word or after DEPTH words.
  task automatic run_prog(input bit gaps, input bit bad_chk);
    int   n = 0;
    bit   done = 0;
    bit   good = 1;
    logic [7:0] sum = 8'h00;
    foreach (prog_q[i]) begin
      if (done) break;
      if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      send_byte(prog_q[i][15:8], 1'b1);
      if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      send_byte(prog_q[i][7:0], 1'b1);
      mem_m[n] = prog_q[i];
      n++;
      sum = sum ^ prog_q[i][15:8] ^ prog_q[i][7:0];
      if (prog_q[i] == 16'h0000 || n == DEPTH) done = 1;
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(bad_chk ? (sum ^ 8'h01) : sum, 1'b1);
    good = !bad_chk;
`else
    good = 1;
`endif
    if (good) exp_q.push_back({32'(last_cyc), 4'(n)});
    idle(2);
    check("instr_count", 32'(instr_count), 32'(n));
    check("prog_done", 32'(prog_done), 32'(good));
    check("err", 32'(err), 32'(!good));
    check_mem();
    // Bytes after completion are ignored.
    send_byte(8'h5A, 1'b0);
    send_byte(8'hA5, 1'b0);
    idle(1);
    check("count_after_extra", 32'(instr_count), 32'(n));
    check("done_after_extra", 32'(prog_done), 32'(good));
    check_mem();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset      = 1'b1;
    clear      = 1'b0;
    host_data  = 8'h00;
    host_valid = 1'b0;
    rd_addr    = '0;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 16'h0000;
    fork monitor(); join_none
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state.
    #1;
    check("rst_host_ready", 32'(host_ready), 32'd1);
    check("rst_prog_done", 32'(prog_done), 32'd0);
    check("rst_start", 32'(start), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_count", 32'(instr_count), 32'd0);
    check_mem();

    // Three words, back-to-back bytes.
    prog_q = '{16'h200F, 16'h4000, 16'h0000};
    run_prog(0, 0);

    // Full memory without END.
    do_clear();
    prog_q = '{16'h2001, 16'h2002, 16'h2003, 16'h2004,
               16'h2005, 16'h2006, 16'h2007, 16'h2008};
    run_prog(0, 0);

    // clear mid-word: the byte presented with clear is dropped.
    do_clear();
    send_byte(8'h20, 1'b1);
    @(negedge clk);
    host_data  = 8'h0F;
    host_valid = 1'b1;
    clear      = 1'b1;
    @(negedge clk);
    clear      = 1'b0;
    host_valid = 1'b0;
    check("clear_count", 32'(instr_count), 32'd0);
    prog_q = '{16'h4000, 16'h0000};
    run_prog(0, 0);

`ifdef LOADER_CHECKSUM_EN
    // Checksum good (2F) and bad (2E) on 20,0F,00,00.
    do_clear();
    prog_q = '{16'h200F, 16'h0000};
    run_prog(0, 0);
    do_clear();
    run_prog(0, 1);
`endif

    // Randomized programs.
    for (int t = 0; t < 20; t++) begin
      int len = $urandom_range(1, DEPTH);
      prog_q.delete();
      for (int i = 0; i < len; i++) prog_q.push_back(16'($urandom_range(1, 16'hFFFF)));
      if (len < DEPTH || $urandom_range(0, 1) == 1) prog_q.push_back(16'h0000);
      do_clear();
      run_prog(1, ($urandom_range(0, 4) == 0));
    end

    // Reset mid-load wipes memory.
    do_clear();
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h56, 1'b1);
    @(negedge clk);
    host_valid = 1'b0;
    reset      = 1'b1;
    @(negedge clk);
    reset      = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 16'h0000;
    #1;
    check("rst2_count", 32'(instr_count), 32'd0);
    check("rst2_host_ready", 32'(host_ready), 32'd1);
    check("rst2_prog_done", 32'(prog_done), 32'd0);
    check_mem();

    idle(4);
    while (exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      tests++;
      fails++;
      $display("FAIL start_missing: got 0 expected 1");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
